// File: rtl/iiitb_icg_pkg.sv
// Shared types and defaults for the iiitb_icg enable controller.
// The state enum and counter widths are used by the controller and by reuse sites.
package iiitb_icg_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        GATED = 2'd2,
        WAKE  = 2'd3
    } icg_state_e;

    localparam int IDLE_W = 8;
    localparam int WAKE_W = 4;

    localparam int IDLE_CYCLES_DEF = 8;
    localparam int WAKE_CYCLES_DEF = 2;

endpackage

// File: rtl/iiitb_sat_cnt.sv
// Parameterised-width up-counter with synchronous clear that sticks at all-ones.
// Used for gate-event counting; also suitable for idle statistics.
module iiitb_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (inc && (count_reg != {W{1'b1}})) begin
            count_next = count_reg + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/iiitb_icg_ctrl.sv
// Enable-side controller for the iiitb_icg clock gate: gates after a run of idle
// cycles, re-enables on demand and holds ready low until the gated clock settles.
module iiitb_icg_ctrl
    import iiitb_icg_pkg::*;
#(
    parameter int IDLE_CYCLES = IDLE_CYCLES_DEF,
    parameter int WAKE_CYCLES = WAKE_CYCLES_DEF,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             act_i,
    input  logic             force_on_i,
    output logic             icg_en_o,
    output logic             ready_o,
    output logic             gated_o,
    output logic [CNT_W-1:0] gate_cnt_o
);

    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_CYCLES - 1);
    localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_CYCLES - 1);

    icg_state_e        state_reg;
    icg_state_e        state_next;
    logic [IDLE_W-1:0] idle_reg;
    logic [IDLE_W-1:0] idle_next;
    logic [WAKE_W-1:0] wake_reg;
    logic [WAKE_W-1:0] wake_next;
    logic              en_reg;
    logic              ready_reg;
    logic              gated_reg;
    logic              gate_inc;

    // Override wins over every state so a scan chain always sees a running clock.
    always_comb begin
        state_next = state_reg;
        idle_next  = idle_reg;
        wake_next  = wake_reg;
        gate_inc   = 1'b0;
        if (force_on_i) begin
            state_next = RUN;
            idle_next  = '0;
            wake_next  = '0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (act_i) begin
                        idle_next = '0;
                    end else if (idle_reg == IDLE_LAST) begin
                        state_next = DRAIN;
                        idle_next  = '0;
                    end else begin
                        idle_next = idle_reg + IDLE_W'(1);
                    end
                end
                DRAIN: begin
                    if (act_i) begin
                        state_next = RUN;
                    end else begin
                        state_next = GATED;
                        gate_inc   = 1'b1;
                    end
                end
                GATED: begin
                    if (act_i) begin
                        state_next = WAKE;
                        wake_next  = '0;
                    end
                end
                WAKE: begin
                    if (wake_reg == WAKE_LAST) begin
                        state_next = RUN;
                        idle_next  = '0;
                    end else begin
                        wake_next = wake_reg + WAKE_W'(1);
                    end
                end
                default: begin
                    state_next = RUN;
                    idle_next  = '0;
                    wake_next  = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= RUN;
            idle_reg  <= '0;
            wake_reg  <= '0;
            en_reg    <= 1'b1;
            ready_reg <= 1'b1;
            gated_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            idle_reg  <= idle_next;
            wake_reg  <= wake_next;
            en_reg    <= (state_next != GATED);
            ready_reg <= (state_next == RUN);
            gated_reg <= (state_next == GATED);
        end
    end

    iiitb_sat_cnt #(
        .W(CNT_W)
    ) u_gate_cnt (
        .clk  (clk),
        .reset(reset),
        .clr  (1'b0),
        .inc  (gate_inc),
        .count(gate_cnt_o)
    );

    assign icg_en_o = en_reg | force_on_i;
    assign ready_o  = ready_reg;
    assign gated_o  = gated_reg;

endmodule

// File: tb/tb_iiitb_icg_ctrl.sv
// Bench for iiitb_icg_ctrl: directed scenarios with literal checks plus randomized
// traffic, all compared each cycle against a behavioural model (wide and 2-bit counter DUTs).
module tb_iiitb_icg_ctrl;

    localparam int IDLE    = 4;
    localparam int WAKE    = 2;
    localparam int W_BIG   = 16;
    localparam int W_SMALL = 2;

    logic clk      = 1'b0;
    logic reset    = 1'b0;
    logic act      = 1'b0;
    logic force_on = 1'b0;

    logic               en_b, ready_b, gated_b;
    logic [W_BIG-1:0]   cnt_b;
    logic               en_s, ready_s, gated_s;
    logic [W_SMALL-1:0] cnt_s;

    int compared   = 0;
    int mismatched = 0;
    bit checking   = 1'b0;

    always #5 clk = ~clk;

    iiitb_icg_ctrl #(.IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE), .CNT_W(W_BIG)) dut_big (
        .clk(clk), .reset(reset), .act_i(act), .force_on_i(force_on),
        .icg_en_o(en_b), .ready_o(ready_b), .gated_o(gated_b), .gate_cnt_o(cnt_b)
    );

    iiitb_icg_ctrl #(.IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE), .CNT_W(W_SMALL)) dut_small (
        .clk(clk), .reset(reset), .act_i(act), .force_on_i(force_on),
        .icg_en_o(en_s), .ready_o(ready_s), .gated_o(gated_s), .gate_cnt_o(cnt_s)
    );

    // Behavioural model: clock asleep flag, one-cycle drain flag, wake countdown, idle streak.
    bit asleep;
    bit drain;
    int wake_left;
    int quiet;
    int entries;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            asleep = 0; drain = 0; wake_left = 0; quiet = 0; entries = 0;
        end else if (force_on) begin
            asleep = 0; drain = 0; wake_left = 0; quiet = 0;
        end else if (asleep) begin
            if (act) begin
                asleep    = 0;
                wake_left = WAKE;
            end
        end else if (wake_left > 0) begin
            wake_left = wake_left - 1;
        end else if (drain) begin
            drain = 0;
            if (!act) begin
                asleep  = 1;
                entries = entries + 1;
            end
        end else if (act) begin
            quiet = 0;
        end else if (quiet == IDLE - 1) begin
            quiet = 0;
            drain = 1;
        end else begin
            quiet = quiet + 1;
        end
    end

    function automatic logic [31:0] sat(input int n, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (n > mx) ? 32'(mx) : 32'(n);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (checking) begin
            check("cyc_en_big",     32'(en_b),    32'(!asleep || force_on));
            check("cyc_ready_big",  32'(ready_b), 32'(!asleep && !drain && wake_left == 0));
            check("cyc_gated_big",  32'(gated_b), 32'(asleep));
            check("cyc_cnt_big",    32'(cnt_b),   sat(entries, W_BIG));
            check("cyc_en_small",   32'(en_s),    32'(!asleep || force_on));
            check("cyc_ready_small",32'(ready_s), 32'(!asleep && !drain && wake_left == 0));
            check("cyc_gated_small",32'(gated_s), 32'(asleep));
            check("cyc_cnt_small",  32'(cnt_s),   sat(entries, W_SMALL));
        end
    end

    task automatic step(input logic a, input logic f);
        act      = a;
        force_on = f;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_to_gated();
        for (int i = 0; i < IDLE + 1; i++) step(1'b0, 1'b0);
    endtask

    logic [W_BIG-1:0] saved_cnt;
    int mode;
    int p_act;

    initial begin
        @(posedge clk);
        #1;
        checking = 1'b1;
        check("rst_en", 32'(en_b), 32'd1);
        check("rst_ready", 32'(ready_b), 32'd1);
        check("rst_gated", 32'(gated_b), 32'd0);
        check("rst_cnt", 32'(cnt_b), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);

        // Reset mid-run for three cycles
        reset = 1'b0;
        #1;
        check("rst_mid_en", 32'(en_b), 32'd1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        check("rst_hold_ready", 32'(ready_b), 32'd1);
        check("rst_hold_cnt", 32'(cnt_b), 32'd0);
        reset = 1'b1;
        $display("txn reset_mid_run: en=%0b ready=%0b gated=%0b cnt=%0d", en_b, ready_b, gated_b, cnt_b);

        // Activity then idle: DRAIN at cycle 14, GATED from 15, wake at 20
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
        check("c14_ready", 32'(ready_b), 32'd0);
        check("c14_en", 32'(en_b), 32'd1);
        check("c14_gated", 32'(gated_b), 32'd0);
        step(1'b0, 1'b0);
        check("c15_en", 32'(en_b), 32'd0);
        check("c15_gated", 32'(gated_b), 32'd1);
        check("c15_cnt", 32'(cnt_b), 32'd1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        check("c21_en", 32'(en_b), 32'd1);
        check("c21_gated", 32'(gated_b), 32'd0);
        check("c21_ready", 32'(ready_b), 32'd0);
        step(1'b0, 1'b0);
        check("c22_ready", 32'(ready_b), 32'd0);
        step(1'b0, 1'b0);
        check("c23_ready", 32'(ready_b), 32'd1);
        $display("txn gate_and_wake: cnt=%0d ready=%0b", cnt_b, ready_b);

        // Idle three, active one, twenty times: never gates
        saved_cnt = cnt_b;
        for (int r = 0; r < 20; r++) begin
            for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
            step(1'b1, 1'b0);
        end
        check("near_idle_cnt", 32'(cnt_b), 32'(saved_cnt));
        check("near_idle_ready", 32'(ready_b), 32'd1);
        $display("txn near_idle_x20: cnt=%0d", cnt_b);

        // Activity exactly in DRAIN returns to RUN
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0);
        check("drain_ready", 32'(ready_b), 32'd0);
        step(1'b1, 1'b0);
        check("drain_abort_ready", 32'(ready_b), 32'd1);
        check("drain_abort_en", 32'(en_b), 32'd1);
        check("drain_abort_cnt", 32'(cnt_b), 32'(saved_cnt));
        $display("txn drain_abort: cnt=%0d", cnt_b);

        // Three full idle->gate->wake loops; 2-bit counter saturates at 3
        for (int r = 0; r < 3; r++) begin
            idle_to_gated();
            step(1'b0, 1'b0);
            step(1'b1, 1'b0);
            for (int i = 0; i < WAKE; i++) step(1'b0, 1'b0);
            $display("txn gate_loop %0d: cnt_big=%0d cnt_small=%0d", r, cnt_b, cnt_s);
        end
        check("loop_cnt_big", 32'(cnt_b), 32'd4);
        check("loop_cnt_small_sat", 32'(cnt_s), 32'd3);

        // Override while gated
        idle_to_gated();
        check("pre_force_gated", 32'(gated_b), 32'd1);
        force_on = 1'b1;
        #1;
        check("force_comb_en", 32'(en_b), 32'd1);
        step(1'b0, 1'b1);
        check("force_run_ready", 32'(ready_b), 32'd1);
        check("force_run_gated", 32'(gated_b), 32'd0);
        check("force_cnt_small_sat", 32'(cnt_s), 32'd3);
        $display("txn force_in_gated: en=%0b ready=%0b", en_b, ready_b);

        // Override held with no activity for 50 cycles
        saved_cnt = cnt_b;
        for (int i = 0; i < 50; i++) step(1'b0, 1'b1);
        check("force_hold_cnt", 32'(cnt_b), 32'(saved_cnt));
        check("force_hold_gated", 32'(gated_b), 32'd0);
        force_on = 1'b0;
        $display("txn force_hold_50: cnt=%0d", cnt_b);

        // Asynchronous reset while gated and while waking
        idle_to_gated();
        reset = 1'b0;
        #1;
        check("areset_gated_en", 32'(en_b), 32'd1);
        check("areset_gated_gated", 32'(gated_b), 32'd0);
        check("areset_gated_cnt", 32'(cnt_b), 32'd0);
        step(1'b0, 1'b0);
        reset = 1'b1;
        idle_to_gated();
        step(1'b1, 1'b0);
        reset = 1'b0;
        #1;
        check("areset_wake_ready", 32'(ready_b), 32'd1);
        step(1'b0, 1'b0);
        reset = 1'b1;
        $display("txn async_reset: en=%0b ready=%0b cnt=%0d", en_b, ready_b, cnt_b);

        // Randomized traffic with occasional override and reset pulses
        mode = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i % 40 == 0) begin
                mode = $urandom_range(0, 3);
                case (mode)
                    0: p_act = 50;
                    1: p_act = 20;
                    2: p_act = 5;
                    default: p_act = 0;
                endcase
            end
            if ($urandom_range(0, 999) == 0) begin
                reset = 1'b0;
                step(1'b0, 1'b0);
                reset = 1'b1;
            end
            step(($urandom_range(0, 99) < p_act) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0);
        end
        $display("txn random_4000: entries=%0d cnt_big=%0d cnt_small=%0d", entries, cnt_b, cnt_s);

        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
